// File: rtl/enc_binder_array_if.sv
// Handshake bundle for enc_binder_array: a valid/ready input for level HVs and a
// valid/ready output for the rotated HVs.
interface enc_binder_array_if #(
  parameter int HV_DIM = 1024,
  parameter int NUM_CH = 10
);
  logic              start_encoding;
  logic              in_ready;
  logic              mode;
  logic [HV_DIM-1:0] level_hv   [0:NUM_CH-1];
  logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1];
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output start_encoding, mode, level_hv, out_ready,
    input  in_ready, shifted_hv, out_valid, busy
  );
  modport slave (
    input  start_encoding, mode, level_hv, out_ready,
    output in_ready, shifted_hv, out_valid, busy
  );
endinterface

// File: rtl/enc_binder_array.sv
// Time-multiplexed HDC binder: captures NUM_CH level HVs, rotates LANES channels per
// cycle by per-channel constant shifts, and presents all results on one handshake.
module enc_binder_lane #(
  parameter int HV_DIM       = 1024,
  parameter int LANES        = 2,
  parameter int P            = 5,
  parameter int PW           = 3,
  parameter int LANE         = 0,
  parameter int SHIFT_BASE   = 0,
  parameter int SHIFT_STRIDE = 1
) (
  input  logic [P-1:0][HV_DIM-1:0] hv_i,
  input  logic [PW-1:0]            pass_i,
  input  logic                     mode_i,
  output logic [HV_DIM-1:0]        hv_o
);
  function automatic logic [HV_DIM-1:0] rot(input logic [HV_DIM-1:0] x, input int s);
    logic [HV_DIM-1:0] r;
    r = '0;
    for (int j = 0; j < HV_DIM; j++) r[(j + s) % HV_DIM] = x[j];
    return r;
  endfunction

  logic [P-1:0][HV_DIM-1:0] rot_l, rot_r;

  // Every shift is a constant, so each rotation is pure wiring; only the pass mux is logic.
  for (genvar p = 0; p < P; p++) begin : g_pass
    localparam int C = p * LANES + LANE;
    localparam int S = (SHIFT_BASE + C * SHIFT_STRIDE) % HV_DIM;
    assign rot_l[p] = rot(hv_i[p], S);
    assign rot_r[p] = rot(hv_i[p], (HV_DIM - S) % HV_DIM);
  end

  always_comb begin
    hv_o = '0;
    for (int p = 0; p < P; p++)
      if (pass_i == PW'(p)) hv_o = mode_i ? rot_r[p] : rot_l[p];
  end
endmodule

module enc_binder_array #(
  parameter int HV_DIM       = 1024,
  parameter int NUM_CH       = 10,
  parameter int LANES        = 2,
  parameter int SHIFT_BASE   = 0,
  parameter int SHIFT_STRIDE = 1
) (
  input  logic               clk,
  input  logic               nrst,
  enc_binder_array_if.slave  bus
);
  localparam int P  = (NUM_CH + LANES - 1) / LANES;
  localparam int PW = $clog2(P + 1);

  typedef enum logic [1:0] {IDLE, BIND, DONE} state_t;

  state_t                          state_q;
  logic [PW-1:0]                   pass_q;
  logic                            mode_q, out_valid_q, in_ready_q, busy_q;
  logic [HV_DIM-1:0]               cap_q     [0:NUM_CH-1];
  logic [HV_DIM-1:0]               shifted_q [0:NUM_CH-1];
  logic [LANES-1:0][P-1:0][HV_DIM-1:0] lane_in;
  logic [LANES-1:0][HV_DIM-1:0]    lane_out;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar p = 0; p < P; p++) begin : g_in
      if (p * LANES + l < NUM_CH) begin : g_used
        assign lane_in[l][p] = cap_q[p * LANES + l];
      end else begin : g_idle
        assign lane_in[l][p] = '0;
      end
    end
    enc_binder_lane #(
      .HV_DIM(HV_DIM), .LANES(LANES), .P(P), .PW(PW), .LANE(l),
      .SHIFT_BASE(SHIFT_BASE), .SHIFT_STRIDE(SHIFT_STRIDE)
    ) u_lane (
      .hv_i(lane_in[l]), .pass_i(pass_q), .mode_i(mode_q), .hv_o(lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) shifted_q[c] <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_encoding) begin
          for (int c = 0; c < NUM_CH; c++) cap_q[c] <= bus.level_hv[c];
          mode_q     <= bus.mode;
          pass_q     <= '0;
          state_q    <= BIND;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        BIND: begin
          // Channels beyond NUM_CH never appear here, so idle lanes write nothing.
          for (int c = 0; c < NUM_CH; c++)
            if (pass_q == PW'(c / LANES)) shifted_q[c] <= lane_out[c % LANES];
          if (pass_q == PW'(P - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            pass_q <= pass_q + PW'(1);
          end
        end
        DONE: if (bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.shifted_hv = shifted_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_enc_binder_array.sv
// Bench for enc_binder_array: two builds (SHIFT_BASE 3 and 14) run in lockstep, each
// with a scoreboard fed at input accept and drained at output handshake.
module tb_enc_binder_array;
  localparam int W = 16, N = 5, L = 2, P = 3;
  typedef logic [W-1:0]          hv_t;
  typedef logic [N-1:0][W-1:0]   pk_t;
  typedef logic [N*W-1:0]        cv_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  enc_binder_array_if #(.HV_DIM(W), .NUM_CH(N)) b0 ();
  enc_binder_array_if #(.HV_DIM(W), .NUM_CH(N)) b1 ();

  assign b1.start_encoding = b0.start_encoding;
  assign b1.mode           = b0.mode;
  assign b1.out_ready      = b0.out_ready;
  assign b1.level_hv       = b0.level_hv;

  enc_binder_array #(.HV_DIM(W), .NUM_CH(N), .LANES(L), .SHIFT_BASE(3), .SHIFT_STRIDE(1))
    u0 (.clk(clk), .nrst(nrst), .bus(b0.slave));
  enc_binder_array #(.HV_DIM(W), .NUM_CH(N), .LANES(L), .SHIFT_BASE(14), .SHIFT_STRIDE(1))
    u1 (.clk(clk), .nrst(nrst), .bus(b1.slave));

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  pk_t q0[$], q1[$];
  int acc_t[$];

  task automatic chk(input string tag, input cv_t act, input cv_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic pk_t pk(input hv_t a [0:N-1]);
    pk_t r;
    for (int c = 0; c < N; c++) r[c] = a[c];
    return r;
  endfunction

  function automatic pk_t model(input pk_t in, input logic m, input int base);
    pk_t r;
    r = '0;
    for (int c = 0; c < N; c++) begin
      int s;
      s = (base + c) % W;
      for (int j = 0; j < W; j++)
        if (!m) r[c][(j + s) % W] = in[c][j];
        else    r[c][(j + W - s) % W] = in[c][j];
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: inputs settle #1 after posedge, so negedge sees the next edge's handshakes.
  always @(negedge clk) begin
    if (nrst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (b0.in_ready && b0.start_encoding) begin
        q0.push_back(model(pk(b0.level_hv), b0.mode, 3));
        acc_t.push_back(cyc);
      end
      if (b1.in_ready && b1.start_encoding) q1.push_back(model(pk(b1.level_hv), b1.mode, 14));
      if (b0.out_valid && b0.out_ready) begin
        if (q0.size() == 0) chk("sb0_empty", cv_t'(0), cv_t'(1));
        else chk("sb0", cv_t'(pk(b0.shifted_hv)), cv_t'(q0.pop_front()));
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) chk("sb1_empty", cv_t'(0), cv_t'(1));
        else chk("sb1", cv_t'(pk(b1.shifted_hv)), cv_t'(q1.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_all(input hv_t v);
    for (int c = 0; c < N; c++) b0.level_hv[c] = v;
  endtask

  // Start a transaction and return the number of edges from accept to out_valid.
  task automatic txn(input logic m, output int lat);
    int k;
    k = 0;
    b0.mode = m;
    b0.start_encoding = 1'b1;
    @(negedge clk);
    while (!b0.in_ready && k < 20) begin @(negedge clk); k++; end
    if (!b0.in_ready) chk("accept_timeout", cv_t'(0), cv_t'(1));
    @(posedge clk); #1;
    b0.start_encoding = 1'b0;
    lat = 0;
    while (!b0.out_valid && lat < 20) begin step(); lat++; end
  endtask

  initial begin
    int lat;
    pk_t snap;
    b0.start_encoding = 1'b0;
    b0.mode = 1'b0;
    b0.out_ready = 1'b0;
    set_all('0);

    repeat (2) step();
    chk("rst_valid", cv_t'(b0.out_valid), cv_t'(0));
    chk("rst_ready", cv_t'(b0.in_ready), cv_t'(1));
    chk("rst_busy",  cv_t'(b0.busy), cv_t'(0));
    chk("rst_hv",    cv_t'(pk(b0.shifted_hv)), cv_t'(0));
    nrst = 1'b0;
    step();

    // bind: single set bit rotated left by 3..7
    b0.out_ready = 1'b1;
    set_all(16'h0001);
    txn(1'b0, lat);
    chk("t1_latency", cv_t'(lat), cv_t'(P));
    chk("t1_hv", cv_t'(pk(b0.shifted_hv)),
        cv_t'({16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008}));
    step();
    chk("t1_idle_ready", cv_t'(b0.in_ready), cv_t'(1));
    chk("t1_idle_valid", cv_t'(b0.out_valid), cv_t'(0));

    // unbind then round trip
    set_all('0);
    b0.level_hv[0] = 16'h0001;
    txn(1'b1, lat);
    chk("t2_unbind", cv_t'(b0.shifted_hv[0]), cv_t'(16'h2000));
    step();
    b0.level_hv[0] = 16'h2000;
    txn(1'b0, lat);
    chk("t2_roundtrip", cv_t'(b0.shifted_hv[0]), cv_t'(16'h0001));
    step();

    // shift wrap on the base-14 build: channel 2 is pass-through
    set_all('0);
    b0.level_hv[2] = 16'hA5C3;
    txn(1'b0, lat);
    chk("t3_wrap", cv_t'(b1.shifted_hv[2]), cv_t'(16'hA5C3));
    chk("t3_ch3", cv_t'(b1.shifted_hv[3]), cv_t'(16'h0000));
    step();

    // backpressure with an ignored start during DONE
    b0.out_ready = 1'b0;
    for (int c = 0; c < N; c++) b0.level_hv[c] = hv_t'(16'h1111 * (c + 1));
    txn(1'b0, lat);
    chk("t4_latency", cv_t'(lat), cv_t'(P));
    snap = model(pk(b0.level_hv), 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin b0.start_encoding = 1'b1; set_all(16'hFFFF); end
      @(negedge clk);
      chk("t4_valid", cv_t'(b0.out_valid), cv_t'(1));
      chk("t4_ready", cv_t'(b0.in_ready), cv_t'(0));
      chk("t4_hold",  cv_t'(pk(b0.shifted_hv)), cv_t'(snap));
      @(posedge clk); #1;
      b0.start_encoding = 1'b0;
    end
    b0.out_ready = 1'b1;
    step();
    chk("t4_busy", cv_t'(b0.busy), cv_t'(0));

    // reset during BIND pass 1
    set_all(16'h8001);
    b0.mode = 1'b0;
    b0.start_encoding = 1'b1;
    step();
    b0.start_encoding = 1'b0;
    step();
    nrst = 1'b1;
    step();
    chk("t5_hv",    cv_t'(pk(b0.shifted_hv)), cv_t'(0));
    chk("t5_valid", cv_t'(b0.out_valid), cv_t'(0));
    chk("t5_ready", cv_t'(b0.in_ready), cv_t'(1));
    nrst = 1'b0;
    set_all(16'h0F0F);
    b0.level_hv[4] = 16'hC001;
    txn(1'b1, lat);
    chk("t5_latency", cv_t'(lat), cv_t'(P));
    step();

    // back-to-back with start held high and fresh data every cycle
    acc_t.delete();
    b0.start_encoding = 1'b1;
    for (int i = 0; i < 25; i++) begin
      for (int c = 0; c < N; c++) b0.level_hv[c] = hv_t'($urandom);
      b0.mode = 1'($urandom_range(0, 1));
      step();
    end
    b0.start_encoding = 1'b0;
    for (int k = 0; k < 10 && b0.busy; k++) step();
    chk("t6_drain", cv_t'(b0.busy), cv_t'(0));
    chk("t6_accepts", cv_t'(acc_t.size()), cv_t'(5));
    for (int i = 1; i < acc_t.size(); i++)
      chk("t6_gap", cv_t'(acc_t[i] - acc_t[i-1]), cv_t'(P + 2));

    step();
    chk("sb0_left", cv_t'(q0.size()), cv_t'(0));
    chk("sb1_left", cv_t'(q1.size()), cv_t'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
